id_stage_ctrl: RTL and testbench

ID_STAGE_CTRL -- requirements
Module: id_stage_ctrl

---
 rtl/rv32_pkg.sv | 30 +++
 rtl/id_ctrl_decode.sv | 43 ++++
 rtl/id_stage_ctrl.sv | 118 +++++++++++
 tb/tb_id_stage_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 decode definitions: base opcodes, immediate-format select
// and the ID-stage buffer state encoding.
package rv32_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_sel_e;

    typedef enum logic [1:0] {
        ST_EMPTY     = 2'd0,
        ST_FULL      = 2'd1,
        ST_INTERLOCK = 2'd2
    } id_state_e;

endpackage

// File: rtl/id_ctrl_decode.sv
// Opcode classifier: immediate format, register-operand usage and
// illegal-opcode flag. Purely combinational.
module id_ctrl_decode
    import rv32_pkg::*;
(
    input  logic [6:0] opcode,
    output imm_sel_e   imm_sel,
    output logic       rs1_used,
    output logic       rs2_used,
    output logic       illegal
);

    always_comb begin
        imm_sel  = IMM_NONE;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OP_OP: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OP_LOAD, OP_IMM, OP_JALR: begin
                imm_sel  = IMM_I;
                rs1_used = 1'b1;
            end
            OP_STORE: begin
                imm_sel  = IMM_S;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OP_BRANCH: begin
                imm_sel  = IMM_B;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OP_LUI, OP_AUIPC: imm_sel = IMM_U;
            OP_JAL:           imm_sel = IMM_J;
            default:          illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_stage_ctrl.sv
// Single-entry decode stage: buffers one fetched instruction, decodes it,
// interlocks on load-use hazards and counts interlock cycles.
//
// Handshakes: an item moves only in a cycle where its valid and ready are both
// high at the rising edge (fetch->ID: if_valid & if_ready; ID->EX: id_valid &
// ex_ready). flush overrides both handshakes in the cycle it is high.
module id_stage_ctrl
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        if_ready,
    input  logic        ex_ready,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    input  logic        flush,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [6:0]  id_opcode,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [4:0]  id_rd,
    output logic [2:0]  id_imm_sel,
    output logic        id_illegal,
    output logic [15:0] stall_cnt,
    output id_state_e   dbg_state
);

    id_state_e   state;
    id_state_e   state_nxt;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;
    logic [15:0] cnt;

    imm_sel_e    dec_imm_sel;
    logic        dec_rs1_used;
    logic        dec_rs2_used;
    logic        dec_illegal;

    logic        hazard;
    logic        transfer;
    logic        accept;
    logic        stall;

    assign id_instr  = buf_instr;
    assign id_pc     = buf_pc;
    assign id_opcode = buf_instr[6:0];
    assign id_rd     = buf_instr[11:7];
    assign id_rs1    = buf_instr[19:15];
    assign id_rs2    = buf_instr[24:20];

    id_ctrl_decode u_decode (
        .opcode   (buf_instr[6:0]),
        .imm_sel  (dec_imm_sel),
        .rs1_used (dec_rs1_used),
        .rs2_used (dec_rs2_used),
        .illegal  (dec_illegal)
    );

    assign id_imm_sel = dec_imm_sel;

    // x0 never carries a load result, so it can never create a hazard.
    assign hazard = (state == ST_FULL) && ex_is_load && (ex_rd != 5'd0) &&
                    ((dec_rs1_used && (id_rs1 == ex_rd)) ||
                     (dec_rs2_used && (id_rs2 == ex_rd)));

    assign id_valid   = rst_n && (state == ST_FULL) && !hazard && !flush;
    assign id_illegal = id_valid && dec_illegal;
    assign transfer   = id_valid && ex_ready;
    assign if_ready   = rst_n && !flush && ((state == ST_EMPTY) || transfer);
    assign accept     = if_valid && if_ready;

    // Both the hazard-detect cycle and the interlock bubble count as stalled.
    assign stall = !flush && (hazard || (state == ST_INTERLOCK));

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) state_nxt = ST_FULL;
                end
                ST_FULL: begin
                    if (hazard)        state_nxt = ST_INTERLOCK;
                    else if (transfer) state_nxt = accept ? ST_FULL : ST_EMPTY;
                end
                ST_INTERLOCK: state_nxt = ST_FULL;
                default:      state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            buf_instr <= 32'd0;
            buf_pc    <= 32'd0;
            cnt       <= 16'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                buf_instr <= if_instr;
                buf_pc    <= if_pc;
            end
            if (stall && (cnt != 16'hFFFF)) cnt <= cnt + 16'd1;
        end
    end

    assign stall_cnt = cnt;
    assign dbg_state = state;

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Directed bench for id_stage_ctrl: inputs change on the falling edge and
// outputs are checked 1 ns later, with hand-computed expected values.
module tb_id_stage_ctrl;
    import rv32_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        ex_ready;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [2:0]  id_imm_sel;
    logic        id_illegal;
    logic [15:0] stall_cnt;
    id_state_e   dbg_state;

    int errors = 0;
    int checks = 0;

    id_stage_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_ready   (if_ready),
        .ex_ready   (ex_ready),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .id_opcode  (id_opcode),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rd      (id_rd),
        .id_imm_sel (id_imm_sel),
        .id_illegal (id_illegal),
        .stall_cnt  (stall_cnt),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // driver: wait for the falling edge, apply inputs, let logic settle
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic exr, input logic ld, input logic [4:0] rd,
                        input logic fl);
        @(negedge clk);
        if_valid   = v;
        if_instr   = ins;
        if_pc      = pc;
        ex_ready   = exr;
        ex_is_load = ld;
        ex_rd      = rd;
        flush      = fl;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0;
        ex_ready = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0; flush = 1'b0;

        // reset with a fetch word offered: nothing may be accepted
        step(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0, 5'd0, 1'b0);
        step(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0, 5'd0, 1'b0);
        chk("rst_if_ready",  32'(if_ready), 32'd0);
        chk("rst_id_valid",  32'(id_valid), 32'd0);
        chk("rst_state",     32'(dbg_state), 32'(ST_EMPTY));
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_opcode",    32'(id_opcode), 32'd0);
        chk("rst_rs1",       32'(id_rs1), 32'd0);
        chk("rst_rs2",       32'(id_rs2), 32'd0);
        chk("rst_rd",        32'(id_rd), 32'd0);
        chk("rst_imm_sel",   32'(id_imm_sel), 32'd0);
        chk("rst_illegal",   32'(id_illegal), 32'd0);

        // addi x1,x0,5: first cycle out of reset accepts it
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("addi_if_ready_first", 32'(if_ready), 32'd1);
        chk("addi_id_valid_n",     32'(id_valid), 32'd0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
        chk("addi_id_valid",  32'(id_valid), 32'd1);
        chk("addi_imm_sel",   32'(id_imm_sel), 32'd1);
        chk("addi_rd",        32'(id_rd), 32'd1);
        chk("addi_rs1",       32'(id_rs1), 32'd0);
        chk("addi_pc",        id_pc, 32'h100);
        chk("addi_illegal",   32'(id_illegal), 32'd0);

        // add x3,x1,x2 behind a load to x2: load-use interlock
        step(1'b1, 32'h002081B3, 32'h180, 1'b1, 1'b1, 5'd2, 1'b0);
        chk("lu_accept", 32'(if_ready), 32'd1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd2, 1'b0);
        chk("lu_hazard_id_valid", 32'(id_valid), 32'd0);
        chk("lu_hazard_if_ready", 32'(if_ready), 32'd0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd2, 1'b0);
        chk("lu_state_interlock", 32'(dbg_state), 32'(ST_INTERLOCK));
        chk("lu_il_id_valid",     32'(id_valid), 32'd0);
        chk("lu_il_if_ready",     32'(if_ready), 32'd0);
        chk("lu_il_stall_cnt",    32'(stall_cnt), 32'd1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
        chk("lu_release_id_valid", 32'(id_valid), 32'd1);
        chk("lu_release_rd",       32'(id_rd), 32'd3);
        chk("lu_release_stall",    32'(stall_cnt), 32'd2);

        // back-to-back stream, with non-hazards from x0 and unused rs2
        step(1'b1, 32'h00112023, 32'h200, 1'b1, 1'b0, 5'd0, 1'b0);
        step(1'b1, 32'h00208463, 32'h204, 1'b1, 1'b1, 5'd0, 1'b0);
        chk("st_sw_valid",   32'(id_valid), 32'd1);
        chk("st_sw_imm",     32'(id_imm_sel), 32'd2);
        chk("st_sw_rs1",     32'(id_rs1), 32'd2);
        chk("st_sw_rs2",     32'(id_rs2), 32'd1);
        chk("st_sw_if_rdy",  32'(if_ready), 32'd1);
        step(1'b1, 32'h000010B7, 32'h208, 1'b1, 1'b1, 5'd0, 1'b0);
        chk("st_beq_valid",  32'(id_valid), 32'd1);
        chk("st_beq_imm",    32'(id_imm_sel), 32'd3);
        chk("st_beq_pc",     id_pc, 32'h204);
        step(1'b1, 32'h008000EF, 32'h20C, 1'b1, 1'b0, 5'd0, 1'b0);
        chk("st_lui_valid",  32'(id_valid), 32'd1);
        chk("st_lui_imm",    32'(id_imm_sel), 32'd4);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd8, 1'b0);
        chk("st_jal_valid",  32'(id_valid), 32'd1);
        chk("st_jal_imm",    32'(id_imm_sel), 32'd5);
        chk("st_jal_pc",     id_pc, 32'h20C);
        chk("st_jal_rs2_8",  32'(id_rs2), 32'd8);

        // illegal opcode held while EX is not ready
        step(1'b1, 32'h0000007F, 32'h300, 1'b0, 1'b0, 5'd0, 1'b0);
        chk("ill_accept", 32'(if_ready), 32'd1);
        step(1'b1, 32'h00500093, 32'h304, 1'b0, 1'b0, 5'd0, 1'b0);
        chk("ill_valid",    32'(id_valid), 32'd1);
        chk("ill_illegal",  32'(id_illegal), 32'd1);
        chk("ill_imm_sel",  32'(id_imm_sel), 32'd0);
        chk("ill_if_ready", 32'(if_ready), 32'd0);
        step(1'b1, 32'h00500093, 32'h304, 1'b0, 1'b0, 5'd0, 1'b0);
        chk("hold_instr", id_instr, 32'h0000007F);
        chk("hold_pc",    id_pc, 32'h300);
        chk("hold_state", 32'(dbg_state), 32'(ST_FULL));

        // flush while FULL with a fetch word offered
        step(1'b1, 32'h00500093, 32'h304, 1'b1, 1'b0, 5'd0, 1'b1);
        chk("fl_if_ready", 32'(if_ready), 32'd0);
        chk("fl_id_valid", 32'(id_valid), 32'd0);
        chk("fl_illegal",  32'(id_illegal), 32'd0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
        chk("fl_state_empty", 32'(dbg_state), 32'(ST_EMPTY));
        chk("fl_not_captured", id_instr, 32'h0000007F);
        chk("fl_id_valid_after", 32'(id_valid), 32'd0);

        // reset taken while in INTERLOCK (rs1 hazard this time)
        step(1'b1, 32'h002081B3, 32'h400, 1'b1, 1'b1, 5'd1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd1, 1'b0);
        chk("ri_hazard_valid", 32'(id_valid), 32'd0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd1, 1'b0);
        chk("ri_interlock", 32'(dbg_state), 32'(ST_INTERLOCK));
        chk("ri_stall_cnt", 32'(stall_cnt), 32'd3);
        rst_n = 1'b0;
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd1, 1'b0);
        chk("ri_state_empty", 32'(dbg_state), 32'(ST_EMPTY));
        chk("ri_stall_zero",  32'(stall_cnt), 32'd0);
        chk("ri_buf_zero",    id_instr, 32'd0);

        // long interlock run: counter must saturate, not wrap
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'h002081B3, 32'h500, 1'b1, 1'b1, 5'd2, 1'b0);
        for (int i = 0; i < 65540; i++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd2, 1'b0);
            if (i == 65534) chk("sat_fffe", 32'(stall_cnt), 32'h0000FFFE);
            if (i == 65535) chk("sat_ffff", 32'(stall_cnt), 32'h0000FFFF);
        end
        chk("sat_hold", 32'(stall_cnt), 32'h0000FFFF);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
        chk("sat_final", 32'(stall_cnt), 32'h0000FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
